// File: rtl/wino_tile_scheduler_if.sv
// Issue, result and layer-config bundle between the Winograd tile scheduler and its environment.
// master = scheduler side; slave = control, tile-fetch and PE side.
interface wino_tile_scheduler_if #(
  parameter int IDX_W = 9,
  parameter int OD_W  = 8
);
  logic             start_i;
  logic [IDX_W-1:0] cfg_tiles_x_i;
  logic [IDX_W-1:0] cfg_tiles_y_i;
  logic [OD_W-1:0]  cfg_od_num_i;
  logic             cfg_size_type_i;
  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [IDX_W-1:0] issue_x_o;
  logic [IDX_W-1:0] issue_y_o;
  logic [OD_W-1:0]  issue_od_o;
  logic             issue_size_type_o;
  logic             issue_last_o;
  logic             result_valid_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [31:0]      stall_cycles_o;

  modport master (
    input  start_i, cfg_tiles_x_i, cfg_tiles_y_i, cfg_od_num_i, cfg_size_type_i,
    input  issue_ready_i, result_valid_i,
    output issue_valid_o, issue_x_o, issue_y_o, issue_od_o, issue_size_type_o, issue_last_o,
    output busy_o, done_o, err_o, stall_cycles_o
  );

  modport slave (
    output start_i, cfg_tiles_x_i, cfg_tiles_y_i, cfg_od_num_i, cfg_size_type_i,
    output issue_ready_i, result_valid_i,
    input  issue_valid_o, issue_x_o, issue_y_o, issue_od_o, issue_size_type_o, issue_last_o,
    input  busy_o, done_o, err_o, stall_cycles_o
  );
endinterface

// File: rtl/wino_tile_scheduler.sv
// Walks od/y/x tiles of one layer pass; first issue 1 cycle after start, up to 1 per cycle,
// valid/ready throttled by MAX_OUTSTANDING credits. WINO_SCHED_PERF_CNT_EN adds the stall counter.
module wino_tile_scheduler #(
  parameter int IDX_W           = 9,
  parameter int OD_W            = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  wino_tile_scheduler_if.master bus
);
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0] x_q, y_q, x_max_q, y_max_q;
  logic [OD_W-1:0]  od_q, od_max_q;
  logic             size_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             start_ok, zero_cfg, credit_ok, at_last, hs, retire;

  assign start_ok  = (state_q == IDLE) && bus.start_i;
  assign zero_cfg  = (bus.cfg_tiles_x_i == '0) || (bus.cfg_tiles_y_i == '0) || (bus.cfg_od_num_i == '0);
  assign credit_ok = cnt_q < MAX_CNT;
  assign at_last   = (x_q == x_max_q) && (y_q == y_max_q) && (od_q == od_max_q);
  assign hs        = (state_q == RUN) && credit_ok && bus.issue_ready_i;
  assign retire    = bus.result_valid_i && (cnt_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = zero_cfg ? DONE : RUN;
      RUN:     if (hs && at_last) state_d = DRAIN;
      DRAIN:   if (cnt_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valid depends only on state and credit so the ready input never loops back into it.
  always_comb begin
    bus.issue_valid_o = 1'b0;
    bus.issue_last_o  = 1'b0;
    bus.busy_o        = 1'b0;
    bus.done_o        = 1'b0;
    case (state_q)
      RUN: begin
        bus.issue_valid_o = credit_ok;
        bus.issue_last_o  = at_last;
        bus.busy_o        = 1'b1;
      end
      DRAIN:   bus.busy_o = 1'b1;
      DONE:    bus.done_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hs && !retire)      cnt_d = cnt_q + CNT_ONE;
    else if (!hs && retire) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      od_q     <= '0;
      x_max_q  <= '0;
      y_max_q  <= '0;
      od_max_q <= '0;
      size_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (start_ok) begin
      x_q      <= '0;
      y_q      <= '0;
      od_q     <= '0;
      x_max_q  <= bus.cfg_tiles_x_i - IDX_W'(1);
      y_max_q  <= bus.cfg_tiles_y_i - IDX_W'(1);
      od_max_q <= bus.cfg_od_num_i - OD_W'(1);
      size_q   <= bus.cfg_size_type_i;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (bus.result_valid_i && (cnt_q == '0)) err_q <= 1'b1;
      // x innermost, then y, then od so one weight tile serves the whole spatial plane
      if (hs) begin
        if (x_q != x_max_q) begin
          x_q <= x_q + IDX_W'(1);
        end else begin
          x_q <= '0;
          if (y_q != y_max_q) begin
            y_q <= y_q + IDX_W'(1);
          end else begin
            y_q  <= '0;
            od_q <= (od_q == od_max_q) ? '0 : od_q + OD_W'(1);
          end
        end
      end
    end
  end

  assign bus.issue_x_o         = x_q;
  assign bus.issue_y_o         = y_q;
  assign bus.issue_od_o        = od_q;
  assign bus.issue_size_type_o = size_q;
  assign bus.err_o             = err_q;

`ifdef WINO_SCHED_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         stall_q <= '0;
    else if (start_ok)                                 stall_q <= '0;
    else if ((state_q == RUN) && !hs && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end

  assign bus.stall_cycles_o = stall_q;
`else
  assign bus.stall_cycles_o = 32'd0;
`endif
endmodule
